// File: rtl/lcd_value_formatter.sv
// Binary-to-decimal formatter for one 16-character LCD line.
// Sequential double-dabble; the display digits update atomically on commit.
`timescale 1ns/1ps
module lcd_value_formatter #(
  parameter int IN_W     = 12,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [IN_W-1:0] value,
  input  logic [3:0]      mux_sel,
  output logic [7:0]      char_out,
  output logic            busy,
  output logic            done,
  output logic            valid
);

  localparam int CNT_W = $clog2(IN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(IN_W - 1);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t            state_reg, state_next;
  logic [IN_W-1:0]   shreg_reg, shreg_next;
  logic [15:0]       bcd_reg, bcd_next, bcd_adj;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [15:0]       disp_reg, disp_next;
  logic              done_reg, done_next;
  logic              valid_reg, valid_next;
  logic [16+IN_W-1:0] shifted;

  // Per-nibble add-3 correction; mod-16, no carry between nibbles.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
    end
  endgenerate

  assign shifted = {bcd_adj, shreg_reg} << 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      shreg_reg <= '0;
      bcd_reg   <= '0;
      cnt_reg   <= '0;
      disp_reg  <= '0;
      done_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      shreg_reg <= shreg_next;
      bcd_reg   <= bcd_next;
      cnt_reg   <= cnt_next;
      disp_reg  <= disp_next;
      done_reg  <= done_next;
      valid_reg <= valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    bcd_next   = bcd_reg;
    cnt_next   = cnt_reg;
    disp_next  = disp_reg;
    done_next  = 1'b0;
    valid_next = valid_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          shreg_next = value;
          bcd_next   = '0;
          cnt_next   = '0;
          state_next = CONV;
        end
      end
      CONV: begin
        {bcd_next, shreg_next} = shifted;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST_ITER) state_next = COMMIT;
      end
      COMMIT: begin
        disp_next  = bcd_reg;
        valid_next = 1'b1;
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy  = (state_reg != IDLE);
  assign done  = done_reg;
  assign valid = valid_reg;

  logic [3:0] d3, d2, d1, d0;
  logic       blank3, blank2, blank1;

  assign d3 = disp_reg[15:12];
  assign d2 = disp_reg[11:8];
  assign d1 = disp_reg[7:4];
  assign d0 = disp_reg[3:0];

  // Blanking cascades from the thousands digit downward; units always shown.
  assign blank3 = BLANK_LZ && (d3 == 4'd0);
  assign blank2 = blank3 && (d2 == 4'd0);
  assign blank1 = blank2 && (d1 == 4'd0);

  always_comb begin
    char_out = 8'h20;
    case (mux_sel)
      4'd0:  char_out = 8'h41;
      4'd1:  char_out = 8'h44;
      4'd2:  char_out = 8'h43;
      4'd3:  char_out = 8'h3D;
      4'd4:  char_out = blank3 ? 8'h20 : {4'h3, d3};
      4'd5:  char_out = blank2 ? 8'h20 : {4'h3, d2};
      4'd6:  char_out = blank1 ? 8'h20 : {4'h3, d1};
      4'd7:  char_out = {4'h3, d0};
      4'd8:  char_out = 8'h20;
      4'd9:  char_out = 8'h4C;
      4'd10: char_out = 8'h53;
      4'd11: char_out = 8'h42;
      default: char_out = 8'h20;
    endcase
  end

endmodule
